// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: one outstanding imem read, instruction register, decode handshake, redirects.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky align_err and halts until reset.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        op_instruction,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              decode_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, HALT = 2'd3} state_e;
`else
  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                squash_q, squash_d;
  logic [ADDR_W-1:0]   target;

  assign target = redirect_target & ~ADDR_W'(3);

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  logic misaligned;
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00) && (state_q != HALT);
  assign align_err  = align_err_q;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    squash_d      = squash_q;
    case (state_q)
      REQ: begin
        if (redirect) fetch_pc_d = target;
        else if (imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = target;
          // redirect coinciding with the returning word kills it immediately
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = fetch_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = target;
          state_d       = REQ;
        end else if (decode_ready) begin
          instr_valid_d = 1'b0;
          fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
          state_d       = REQ;
        end
      end
      default: state_d = state_q;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    align_err_d = align_err_q;
    if (misaligned) begin
      state_d       = HALT;
      instr_valid_d = 1'b0;
      squash_d      = 1'b0;
      align_err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= REQ;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      squash_q      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      squash_q      <= squash_d;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_q   <= align_err_d;
`endif
    end
  end

  // Combinational outputs are held low while reset is asserted
  assign imem_req       = rst_n && (state_q == REQ) && !redirect;
  assign imem_addr      = rst_n ? fetch_pc_q : '0;
  assign pc_plus4       = rst_n ? (pc_q + ADDR_W'(4)) : '0;
  assign op_instruction = rst_n ? instr_q[31:26] : 6'b0;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign instr_valid    = instr_valid_q;

endmodule
